// File: rtl/lsb_scan_scheduler.sv
// Lowest-set-bit scan scheduler. It accepts a request word, emits the index of
// each set bit from lowest to highest, and then reports how many were emitted.
module lsb_scan_scheduler #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDX_W = 5,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    input  logic             abort,
    output logic             done,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] word_n;
    logic [WIDTH-1:0] iso_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [IDX_W-1:0] index_n;
    logic             last_n;

    // Next-state and working-word update; abort overrides every state.
    always_comb begin
        state_n = state;
        word_n  = word;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    word_n  = in_word;
                    cnt_n   = '0;
                    state_n = (in_word != '0) ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    word_n = word & (word - WIDTH'(1));
                    cnt_n  = cnt + CNT_W'(1);
                    if (out_last) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (abort) begin
            state_n = IDLE;
            word_n  = '0;
            cnt_n   = cnt;
        end
    end

    // Isolate and encode the lowest set bit of the next working word so the
    // registered index and last flag line up with the word they describe.
    always_comb begin
        iso_n   = word_n & (~word_n + WIDTH'(1));
        index_n = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (iso_n[i]) begin
                index_n = IDX_W'(i);
            end
        end
        last_n = (state_n == SCAN) && ((word_n & (word_n - WIDTH'(1))) == '0);
        if (state_n != SCAN) begin
            index_n = '0;
        end
    end

    // State, working word, count and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            word       <= '0;
            cnt        <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_index  <= '0;
            out_last   <= 1'b0;
            done       <= 1'b0;
            done_count <= '0;
        end else begin
            state     <= state_n;
            word      <= word_n;
            cnt       <= cnt_n;
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == SCAN);
            out_index <= index_n;
            out_last  <= last_n;
            done      <= (state_n == DONE);
            if (state_n == DONE) begin
                done_count <= cnt_n;
            end
        end
    end

endmodule

// File: tb/tb_lsb_scan_scheduler.sv
// Scoreboard bench for lsb_scan_scheduler: stimulus pushes the expected index
// stream and count, and a negedge monitor pops and compares on every output.
module tb_lsb_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_index;
    logic        out_last;
    logic        abort = 1'b0;
    logic        done;
    logic [5:0]  done_count;

    typedef struct {
        bit is_done;
        int val;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   mode = 0;
    int   model_count = 0;

    lsb_scan_scheduler #(.WIDTH(32), .IDX_W(5), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last),
        .abort     (abort),
        .done      (done),
        .done_count(done_count)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: every set bit ascending, last on the highest, then the count.
    task automatic push_model(input logic [31:0] w);
        int   n;
        int   seen;
        exp_t e;
        n = $countones(w);
        seen = 0;
        for (int i = 0; i < 32; i++) begin
            if (w[i]) begin
                seen++;
                e.is_done = 1'b0;
                e.val = i;
                e.last = (seen == n);
                exp_q.push_back(e);
            end
        end
        e.is_done = 1'b1;
        e.val = n;
        e.last = 1'b0;
        exp_q.push_back(e);
    endtask

    // Consumer ready pattern: 0 tied high, 1 toggling, 2 random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each index handshake and each done pulse.
    initial begin
        bit         prev_stall;
        bit         prev_done;
        logic [4:0] prev_idx;
        logic       prev_last;
        exp_t       e;
        prev_stall = 1'b0;
        prev_done  = 1'b0;
        prev_idx   = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (out_valid && done) begin
                    chk("valid_with_done", 32'(out_valid && done), 32'd0);
                end
                if (prev_stall) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_index", 32'(out_index), 32'(prev_idx));
                    chk("stall_last", 32'(out_last), 32'(prev_last));
                end
                if (prev_done) begin
                    chk("ready_after_done", 32'(in_ready), 32'd1);
                end
                if (out_valid && out_ready && !abort) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_index", 32'(out_index), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("index_kind", 32'(e.is_done), 32'd0);
                        chk("index", 32'(out_index), 32'(e.val));
                        chk("last", 32'(out_last), 32'(e.last));
                    end
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 32'(done_count), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_kind", 32'(e.is_done), 32'd1);
                        chk("done_count", 32'(done_count), 32'(e.val));
                        model_count = e.val;
                    end
                end
                prev_stall = out_valid && !out_ready && !abort;
                prev_done  = done;
                prev_idx   = out_index;
                prev_last  = out_last;
            end
        end
    end

    // Offer one word, then wait for its done pulse with a cycle budget.
    task automatic send_word(input logic [31:0] w, input int md);
        int k;
        bit got;
        mode = md;
        @(posedge clk);
        #1;
        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            return;
        end
        push_model(w);
        in_valid = 1'b1;
        in_word  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_word  = $urandom;
        got = 1'b0;
        for (k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("first_valid", 32'(out_valid), 32'(w != 0));
                chk("first_done", 32'(done), 32'(w == 0));
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        if (md == 0) begin
            chk("done_latency", 32'(k), 32'($countones(w) + 1));
        end
    endtask

    initial begin
        logic [31:0] w;
        // Reset held for three cycles with all outputs low.
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs",
                32'({in_ready, out_valid, out_index, out_last, done, done_count}), 32'd0);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);
        chk("valid_after_reset", 32'(out_valid), 32'd0);

        send_word(32'h0000_8014, 0);
        send_word(32'h0000_0000, 0);
        send_word(32'hFFFF_FFFF, 1);
        send_word(32'h8000_0000, 2);

        // Abort on the cycle index 31 is presented with the consumer ready.
        mode = 0;
        @(posedge clk);
        #1;
        chk("abort_pre_ready", 32'(in_ready), 32'd1);
        push_model(32'h8000_0001);
        in_valid = 1'b1;
        in_word  = 32'h8000_0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_presented_idx", 32'(out_index), 32'd31);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_count_kept", 32'(done_count), 32'(model_count));
        exp_q.delete();
        send_word(32'h0000_0100, 0);

        // Abort in IDLE blocks acceptance of an offered word.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_word  = 32'h0000_0005;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        @(negedge clk);
        chk("idle_abort_valid", 32'(out_valid), 32'd0);
        chk("idle_abort_done", 32'(done), 32'd0);
        chk("idle_abort_ready", 32'(in_ready), 32'd1);

        // Randomised words with a random consumer.
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: w = $urandom;
                1: w = $urandom & $urandom & $urandom;
                2: w = 32'h1 << $urandom_range(0, 31);
                default: w = (n % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
            endcase
            send_word(w, 2);
        end

        // Asynchronous reset in the middle of a scan.
        mode = 0;
        @(posedge clk);
        #1;
        push_model(32'h0000_00F0);
        in_valid = 1'b1;
        in_word  = 32'h0000_00F0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        chk("pre_reset_index", 32'(out_index), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("async_valid_drop", 32'(out_valid), 32'd0);
        chk("async_ready_drop", 32'(in_ready), 32'd0);
        exp_q.delete();
        model_count = 0;
        repeat (2) begin
            @(negedge clk);
            chk("midscan_reset_outputs",
                32'({in_ready, out_valid, out_index, out_last, done, done_count}), 32'd0);
        end
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rereset", 32'(in_ready), 32'd1);
        chk("count_after_rereset", 32'(done_count), 32'd0);
        send_word(32'h0000_0003, 0);

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsb_scan_scheduler.md
Name: lsb_scan_scheduler

Overview:
Sequential scheduler around the lowest-set-bit datapath. It accepts a 32-bit request word and emits the index of each set bit, lowest first, one per output handshake. Each emitted bit is cleared from the working copy. When the word is exhausted it reports completion with a count. It sits between a request-mask producer (interrupt/pending vectors, free-list masks) and a consumer that services one index at a time.

Parameters:
WIDTH, 32, request word width; power of two, 2..32
IDX_W, 5, index width; equals log2(WIDTH)
CNT_W, 6, count width; equals IDX_W+1 so WIDTH itself is representable

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request word offered
in_ready  output  1  scheduler can accept a word
in_word  input  WIDTH  request mask
out_valid  output  1  index available
out_ready  input  1  consumer accepts index
out_index  output  IDX_W  index of lowest set bit of working word
out_last  output  1  current index is the final set bit
abort  input  1  synchronous flush to IDLE
done  output  1  one-cycle pulse: word fully scanned or empty word accepted
done_count  output  CNT_W  number of indices emitted for the finished word; held until next accept

Behaviour:
- Reset (rst_n low, async): state=IDLE; working word=0; in_ready=0 while rst_n low, 1 from the first cycle in IDLE; out_valid=0; out_index=0; out_last=0; done=0; done_count=0; internal count=0.
- States: IDLE, SCAN, DONE.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid&in_ready: capture in_word and clear the internal count.
  - If the word is nonzero, go to SCAN.
  - If the word is zero, go to DONE with count 0.
- SCAN: in_ready=0, out_valid=1.
  - out_index = position of the lowest set bit of the working word, isolated as w & (~w+1), then encoded.
  - out_last=1 when the working word has exactly one bit set ((w & (w-1))==0).
  - out_index and out_last are stable while out_valid&!out_ready.
  - On out_valid&out_ready: clear that bit (w <= w & (w-1)) and increment the count. If out_last, go to DONE.
- DONE: done=1 for exactly one cycle. done_count is loaded with the final count on the same edge done asserts. Next state is IDLE.
- Latency:
  - Word accepted at edge N -> out_valid high in cycle N+1.
  - Back-to-back out_ready -> one index per cycle.
  - Last handshake at edge M -> done high in cycle M+1 -> in_ready high in cycle M+2.
  - Empty word accepted at edge N -> done in cycle N+1 with done_count=0.
- Bit WIDTH-1 set only -> out_index=WIDTH-1, out_last=1. All bits set -> WIDTH indices 0..WIDTH-1 in order, then done_count=WIDTH (32 with default parameters; no overflow).
- abort (synchronous, highest priority after reset):
  - In any state, the next state is IDLE and the working word is cleared. No done pulse; done_count is unchanged.
  - A handshake coincident with abort is ignored: no bit clear, no count increment.
  - abort in IDLE with in_valid: the word is not accepted.
- in_word is sampled only on accept; later changes to in_word have no effect.
- out_ready outside SCAN is ignored. in_valid outside IDLE is not accepted and must be held by the producer.
- Reset asserted mid-scan: immediately return to the reset values above; the partial word is lost.

Test Plan:
1. Reset with rst_n low 3 cycles, then release -> all outputs 0 during reset; in_ready=1 in the first cycle after release.
2. Accept in_word=0x0000_8014 with out_ready tied high -> out_index sequence 2, 4, 15 on consecutive cycles; out_last only with 15; done pulse next cycle with done_count=3; in_ready=1 one cycle later.
3. Accept 0x0000_0000 -> no out_valid; done one cycle after accept with done_count=0.
4. Accept 0xFFFF_FFFF with out_ready toggling 1,0,1,0 -> indices 0..31 in order; out_index held during stall cycles; done_count=32.
5. Accept 0x8000_0001; handshake index 0; assert abort on the cycle index 31 is presented with out_ready=1 -> no done pulse; done_count keeps its previous value; in_ready=1 next cycle; new word 0x0000_0100 yields index 8.
6. Drop rst_n asynchronously mid-scan of 0x0000_00F0 after index 4 -> out_valid falls without a clock edge; after release, state is IDLE and done_count=0.
